// File: rtl/slave_port_arbiter.sv
// Two-master, one-slave port arbiter with round-robin grant, single-outstanding
// transaction FSM (IDLE/BUSY/DONE) and a watchdog that completes hung transfers.
module slave_port_arbiter #(
  parameter bit SLAVE_ID = 1'b0,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              master_0_req,
  input  logic              master_0_cmd,
  input  logic [DATA_W-1:0] master_0_addr,
  input  logic [DATA_W-1:0] master_0_wdata,
  output logic [DATA_W-1:0] master_0_rdata,
  output logic              master_0_ack,
  input  logic              master_1_req,
  input  logic              master_1_cmd,
  input  logic [DATA_W-1:0] master_1_addr,
  input  logic [DATA_W-1:0] master_1_wdata,
  output logic [DATA_W-1:0] master_1_rdata,
  output logic              master_1_ack,
  output logic              slave_req,
  output logic              slave_cmd,
  output logic [DATA_W-1:0] slave_addr,
  output logic [DATA_W-1:0] slave_wdata,
  input  logic [DATA_W-1:0] slave_rdata,
  input  logic              slave_ack,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);

  state_t            state;
  logic              grant;
  logic              last_grant;
  logic [WD_W-1:0]   wdog;

  logic              elig_0;
  logic              elig_1;
  logic              next_grant;
  logic              timeout_hit;
  logic              complete;
  logic [DATA_W-1:0] done_rdata;

  assign elig_0 = master_0_req && (master_0_addr[31] == SLAVE_ID);
  assign elig_1 = master_1_req && (master_1_addr[31] == SLAVE_ID);

  // On a tie the pointer hands the grant to whoever was not served last.
  assign next_grant  = (elig_0 && elig_1) ? ~last_grant : elig_1;
  assign timeout_hit = (TIMEOUT != 0) && (wdog == WD_W'(TIMEOUT));
  assign complete    = slave_ack || timeout_hit;
  assign done_rdata  = slave_ack ? slave_rdata : TIMEOUT_DATA;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      grant          <= 1'b0;
      last_grant     <= 1'b1;
      wdog           <= '0;
      timeout_err    <= 1'b0;
      master_0_ack   <= 1'b0;
      master_1_ack   <= 1'b0;
      master_0_rdata <= '0;
      master_1_rdata <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every branch sees
      // the pre-edge values of grant/wdog regardless of statement order.
      case (state)
        IDLE: begin
          if (elig_0 || elig_1) begin
            grant <= next_grant;
            wdog  <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (complete) begin
            if (grant) begin
              master_1_rdata <= done_rdata;
              master_1_ack   <= 1'b1;
            end else begin
              master_0_rdata <= done_rdata;
              master_0_ack   <= 1'b1;
            end
            last_grant <= grant;
            state      <= DONE;
            if (!slave_ack) timeout_err <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DONE: begin
          master_0_ack <= 1'b0;
          master_1_ack <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through this block
    // can leave one unassigned and infer a latch.
    slave_req   = 1'b0;
    slave_cmd   = 1'b0;
    slave_addr  = '0;
    slave_wdata = '0;
    if (state == BUSY) begin
      slave_req = 1'b1;
      if (grant) begin
        slave_cmd   = master_1_cmd;
        slave_addr  = master_1_addr;
        slave_wdata = master_1_wdata;
      end else begin
        slave_cmd   = master_0_cmd;
        slave_addr  = master_0_addr;
        slave_wdata = master_0_wdata;
      end
    end
  end

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Scoreboard bench for slave_port_arbiter: stimulus queues expected slave
// transactions and master completions; monitors pop and compare on each event.
module tb_slave_port_arbiter;

  typedef struct {
    logic        m;
    logic [31:0] rdata;
    logic        terr;
  } ack_exp_t;

  typedef struct {
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } slv_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        master_0_req = 1'b0, master_0_cmd = 1'b0;
  logic [31:0] master_0_addr = '0, master_0_wdata = '0, master_0_rdata;
  logic        master_0_ack;
  logic        master_1_req = 1'b0, master_1_cmd = 1'b0;
  logic [31:0] master_1_addr = '0, master_1_wdata = '0, master_1_rdata;
  logic        master_1_ack;
  logic        slave_req, slave_cmd;
  logic [31:0] slave_addr, slave_wdata;
  logic [31:0] slave_rdata = '0;
  logic        slave_ack = 1'b0;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  ack_exp_t    sb[$];
  slv_exp_t    slv_q[$];
  logic [31:0] rd_q[$];

  int ack_delay  = 1;
  bit ack_always = 0;

  slave_port_arbiter #(.SLAVE_ID(1'b1), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .master_0_req(master_0_req), .master_0_cmd(master_0_cmd),
    .master_0_addr(master_0_addr), .master_0_wdata(master_0_wdata),
    .master_0_rdata(master_0_rdata), .master_0_ack(master_0_ack),
    .master_1_req(master_1_req), .master_1_cmd(master_1_cmd),
    .master_1_addr(master_1_addr), .master_1_wdata(master_1_wdata),
    .master_1_rdata(master_1_rdata), .master_1_ack(master_1_ack),
    .slave_req(slave_req), .slave_cmd(slave_cmd), .slave_addr(slave_addr),
    .slave_wdata(slave_wdata), .slave_rdata(slave_rdata), .slave_ack(slave_ack),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Slave model: acks on the ack_delay-th BUSY cycle (0 = never), or always.
  bit in_busy = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (slave_req) begin
      if (!in_busy) begin
        in_busy = 1;
        busy_cnt = 0;
        slave_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
      end
      busy_cnt++;
      slave_ack = ack_always || (ack_delay != 0 && busy_cnt == ack_delay);
    end else begin
      in_busy = 0;
      slave_ack = ack_always;
    end
  end

  // Monitor: slave-side transaction start and master-side completions.
  logic       prev_sreq = 1'b0;
  logic [1:0] prev_acks = 2'b00;
  always @(negedge clk) begin
    logic [1:0] acks;
    ack_exp_t   e;
    slv_exp_t   s;
    acks = {master_1_ack, master_0_ack};
    if (slave_req && !prev_sreq) begin
      if (slv_q.size() == 0) check("unexpected_slave_req", slave_req, 0);
      else begin
        s = slv_q.pop_front();
        check("slave_cmd", slave_cmd, s.cmd);
        check("slave_addr", slave_addr, s.addr);
        check("slave_wdata", slave_wdata, s.wdata);
      end
    end
    if (prev_acks != 2'b00) check("ack_pulse", prev_acks & acks, 0);
    if (acks != 2'b00) begin
      if (sb.size() == 0) check("unexpected_ack", acks, 0);
      else begin
        e = sb.pop_front();
        check("ack_master", acks, e.m ? 32'd2 : 32'd1);
        check("ack_rdata", e.m ? master_1_rdata : master_0_rdata, e.rdata);
        check("ack_timeout_err", timeout_err, e.terr);
      end
    end
    prev_sreq = slave_req;
    prev_acks = acks;
  end

  task automatic expect_txn(input logic m, input logic cmd, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] srd,
                            input logic [31:0] erd, input logic terr, input bit acked);
    slv_exp_t s;
    ack_exp_t e;
    s.cmd = cmd; s.addr = addr; s.wdata = wdata;
    slv_q.push_back(s);
    rd_q.push_back(srd);
    if (acked) begin
      e.m = m; e.rdata = erd; e.terr = terr;
      sb.push_back(e);
    end
  endtask

  task automatic drive(input logic m, input logic cmd, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (m) begin
      master_1_req = 1; master_1_cmd = cmd; master_1_addr = addr; master_1_wdata = wdata;
    end else begin
      master_0_req = 1; master_0_cmd = cmd; master_0_addr = addr; master_0_wdata = wdata;
    end
  endtask

  // Waits (bounded) for master m's ack; masters drop req once they see their ack.
  task automatic wait_ack(input logic m, input int budget, input string name);
    bit seen;
    seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      seen = m ? master_1_ack : master_0_ack;
      if (master_0_ack) master_0_req = 0;
      if (master_1_ack) master_1_req = 0;
    end
    check(name, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int prev_cyc;
    bit seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_slave_req", slave_req, 0);
    check("rst_acks", {master_1_ack, master_0_ack}, 0);
    check("rst_rdata0", master_0_rdata, 0);
    check("rst_rdata1", master_1_rdata, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1;

    // Tie after reset: M0 read wins, then M1 write two cycles after M0's ack
    @(negedge clk);
    ack_delay = 2;
    expect_txn(0, 0, 32'h8000_0010, 32'h0, 32'hfeed00c0, 32'hfeed00c0, 0, 1);
    expect_txn(1, 1, 32'h8000_0020, 32'h1111_2222, 32'hc0de_0001, 32'hc0de_0001, 0, 1);
    drive(0, 0, 32'h8000_0010, 32'h0);
    drive(1, 1, 32'h8000_0020, 32'h1111_2222);
    @(posedge clk); @(negedge clk);
    check("tie_req_latency", slave_req, 1);
    check("tie_m0_first", slave_addr, 32'h8000_0010);
    wait_ack(0, 8, "tie_m0_ack");
    @(negedge clk);
    check("tie_m0_ack_width", master_0_ack, 0);
    check("tie_idle_gap", slave_req, 0);
    @(negedge clk);
    check("tie_m1_granted", slave_req, 1);
    check("tie_m1_addr", slave_addr, 32'h8000_0020);
    check("tie_m0_rdata_hold", master_0_rdata, 32'hfeed00c0);
    wait_ack(1, 8, "tie_m1_ack");

    // M1 alone three times
    ack_delay = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_txn(1, 0, 32'h8000_0100 + i, 32'h0, 32'h1000_0000 + i, 32'h1000_0000 + i, 0, 1);
      drive(1, 0, 32'h8000_0100 + i, 32'h0);
      @(posedge clk); @(negedge clk);
      check($sformatf("m1_solo_latency_%0d", i), slave_req, 1);
      wait_ack(1, 6, $sformatf("m1_solo_ack_%0d", i));
    end

    // Wrong slave id is ignored; fixing addr[31] while waiting gets re-evaluated
    @(negedge clk);
    drive(0, 0, 32'h0000_0040, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("wrong_id_no_req_%0d", i), slave_req, 0);
    end
    check("wrong_id_no_ack", master_0_ack, 0);
    expect_txn(0, 0, 32'h8000_0040, 32'h0, 32'h2020_2020, 32'h2020_2020, 0, 1);
    master_0_addr = 32'h8000_0040;
    @(posedge clk); @(negedge clk);
    check("reeval_granted", slave_req, 1);
    wait_ack(0, 6, "reeval_ack");

    // Ack on the timeout cycle counts as normal; no preemption during BUSY
    @(negedge clk);
    ack_delay = 5;
    expect_txn(1, 1, 32'h8000_0200, 32'ha5a5_0001, 32'h2222_0001, 32'h2222_0001, 0, 1);
    expect_txn(0, 0, 32'h8000_0300, 32'h0, 32'h3333_0001, 32'h3333_0001, 0, 1);
    drive(1, 1, 32'h8000_0200, 32'ha5a5_0001);
    @(posedge clk); @(negedge clk);
    drive(0, 0, 32'h8000_0300, 32'h0);
    repeat (2) @(negedge clk);
    check("no_preempt_addr", slave_addr, 32'h8000_0200);
    wait_ack(1, 10, "edge_timeout_ack");
    check("write_loads_rdata", master_1_rdata, 32'h2222_0001);
    check("edge_timeout_no_err", timeout_err, 0);
    wait_ack(0, 12, "after_busy_m0_ack");

    // slave_ack held high with both requesting: alternate every 3 cycles
    @(negedge clk);
    ack_always = 1;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0)
        expect_txn(1, 0, 32'h8000_0b00, 32'h0, 32'h4000_0000 + k, 32'h4000_0000 + k, 0, 1);
      else
        expect_txn(0, 0, 32'h8000_0a00, 32'h0, 32'h4000_0000 + k, 32'h4000_0000 + k, 0, 1);
    end
    drive(0, 0, 32'h8000_0a00, 32'h0);
    drive(1, 0, 32'h8000_0b00, 32'h0);
    prev_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      seen = 0;
      for (int n = 0; n < 8 && !seen; n++) begin
        @(negedge clk);
        seen = master_0_ack | master_1_ack;
      end
      check($sformatf("rr_ack_%0d", k), seen, 1);
      if (k > 0) check($sformatf("rr_spacing_%0d", k), cyc - prev_cyc, 3);
      prev_cyc = cyc;
    end
    master_0_req = 0;
    master_1_req = 0;
    ack_always = 0;

    // Watchdog: slave never acks, completion on the 5th BUSY edge
    repeat (2) @(negedge clk);
    ack_delay = 0;
    expect_txn(0, 0, 32'h8000_0c00, 32'h0, 32'h5555_5555, 32'hdeadbeef, 1, 1);
    drive(0, 0, 32'h8000_0c00, 32'h0);
    @(posedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("wd_busy_%0d", i), {slave_req, master_0_ack}, 2'b10);
    end
    @(negedge clk);
    check("wd_ack_edge", master_0_ack, 1);
    master_0_req = 0;
    repeat (3) @(negedge clk);
    check("wd_err_sticky", timeout_err, 1);
    ack_delay = 1;
    expect_txn(1, 0, 32'h8000_0c10, 32'h0, 32'h5a5a_0000, 32'h5a5a_0000, 1, 1);
    drive(1, 0, 32'h8000_0c10, 32'h0);
    wait_ack(1, 6, "wd_err_still_set_ack");

    // Reset mid-BUSY aborts; next tie arbitrates as after power-up
    @(negedge clk);
    ack_delay = 0;
    expect_txn(1, 1, 32'h8000_0d00, 32'h7777_7777, 32'h0, 32'h0, 0, 0);
    drive(1, 1, 32'h8000_0d00, 32'h7777_7777);
    @(posedge clk); @(negedge clk);
    check("abort_busy", slave_req, 1);
    #2 reset = 0;
    #1;
    check("abort_slave_req", slave_req, 0);
    check("abort_slave_addr", slave_addr, 0);
    check("abort_slave_wdata", slave_wdata, 0);
    check("abort_acks", {master_1_ack, master_0_ack}, 0);
    check("abort_rdata0", master_0_rdata, 0);
    check("abort_rdata1", master_1_rdata, 0);
    check("abort_timeout_err", timeout_err, 0);
    master_1_req = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    ack_delay = 1;
    expect_txn(0, 0, 32'h8000_0e00, 32'h0, 32'h6666_0000, 32'h6666_0000, 0, 1);
    expect_txn(1, 0, 32'h8000_0f00, 32'h0, 32'h6666_0001, 32'h6666_0001, 0, 1);
    drive(0, 0, 32'h8000_0e00, 32'h0);
    drive(1, 0, 32'h8000_0f00, 32'h0);
    wait_ack(0, 6, "post_reset_m0_ack");
    wait_ack(1, 6, "post_reset_m1_ack");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("slave_queue_drained", slv_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slave_port_arbiter.md
SLAVE_PORT_ARBITER -- requirements
Module: slave_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- SLAVE_ID, default 0: value of addr[31] that targets this slave.
- DATA_W, default 32: width of addr, wdata and rdata.
- TIMEOUT, default 255: watchdog limit in cycles; 0 disables the watchdog.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock; all state changes on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- master_N_req (N=0,1), in, 1: request; held until master_N_ack is seen.
- master_N_cmd, in, 1: 0 = read, 1 = write; stable while req=1.
- master_N_addr, in, DATA_W: address; bit 31 selects the slave.
- master_N_wdata, in, DATA_W: write data.
- master_N_rdata, out, DATA_W: registered read data.
- master_N_ack, out, 1: one-cycle completion pulse.
- slave_req, out, 1: transaction valid towards the slave.
- slave_cmd, out, 1: copy of the granted master's cmd.
- slave_addr, out, DATA_W: copy of the granted master's addr.
- slave_wdata, out, DATA_W: copy of the granted master's wdata.
- slave_rdata, in, DATA_W: slave read data, valid with slave_ack.
- slave_ack, in, 1: slave completion, sampled in BUSY only.
- timeout_err, out, 1: sticky flag set by a watchdog expiry.

Function
REQ-003 A master request SHALL be eligible only when master_N_req=1 and master_N_addr[31]=SLAVE_ID.
REQ-004 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-005 In IDLE with any eligible request, the block SHALL register grant and go to BUSY; with none, it SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin on a 1-bit last_grant pointer: if both masters are eligible, the master != last_grant wins; a single eligible master wins regardless of the pointer.
REQ-007 In BUSY, slave_req SHALL be 1 and slave_cmd/addr/wdata SHALL be combinational copies of the granted master's inputs; in IDLE and DONE, slave_req SHALL be 0 and the slave outputs SHALL be 0.
REQ-008 On a BUSY edge with slave_ack=1, the block SHALL:
- register slave_rdata into master_G_rdata, where G is the granted master;
- set master_G_ack=1;
- update last_grant to G;
- go to DONE.
REQ-009 DONE SHALL last exactly one cycle, with master_G_ack=1 throughout and the other master's ack=0, then return to IDLE.
REQ-010 master_N_rdata SHALL hold its last value until the next completion for that master; writes SHALL also load slave_rdata.
REQ-011 Latency SHALL be 1 cycle from request to slave_req and 1 cycle from slave_ack to master ack; minimum spacing between transactions SHALL be 3 cycles.
REQ-012 The watchdog SHALL be an 8-bit-or-wider counter, cleared on entry to BUSY and incremented each BUSY cycle without slave_ack.
REQ-013 When the watchdog reaches TIMEOUT (TIMEOUT != 0), the block SHALL complete as in REQ-008 but with rdata = 32'hDEADBEEF, and SHALL set timeout_err=1.
REQ-014 slave_ack and timeout in the same cycle SHALL be treated as a normal ack, with no error.
REQ-015 A grant SHALL NOT be preempted: a request from, or withdrawal by, either master during BUSY SHALL have no effect until the return to IDLE.
REQ-016 slave_ack received in IDLE or DONE SHALL be ignored.
REQ-017 An eligible request whose addr[31] changes while waiting SHALL be re-evaluated on every IDLE cycle.

Reset
REQ-018 reset=0 SHALL immediately (asynchronously) force:
- state = IDLE, last_grant = 1 (so master 0 wins the first tie);
- watchdog = 0, timeout_err = 0;
- all acks = 0, slave_req = 0, all rdata = 0.
REQ-019 A reset asserted mid-transaction SHALL abort the transaction with no ack; timeout_err SHALL clear only by reset.

Verification
REQ-020 Reset then both masters request SLAVE_ID (M0 read, M1 write) -> M0 is granted first; after slave_ack with rdata=32'hfeed00c0, master_0_rdata=32'hfeed00c0, master_0_ack pulses for 1 cycle, then M1 is granted 2 cycles later.
REQ-021 M1 requests alone 3 consecutive times -> M1 is granted each time; slave_req rises 1 cycle after each IDLE sample.
REQ-022 Master addr[31] != SLAVE_ID -> slave_req stays 0 and no ack is issued.
REQ-023 TIMEOUT=4 with a slave that never acks -> ack on the 5th BUSY cycle edge, rdata=32'hDEADBEEF, timeout_err=1 until reset.
REQ-024 reset pulsed low during BUSY -> all outputs are 0 within the same cycle; the next request arbitrates as after power-up.
REQ-025 slave_ack held high continuously with both masters requesting -> the masters alternate with 3-cycle spacing and never receive a double ack.
